// File: rtl/alu_pkg.sv
// Shared opcode encodings, entry widths and helpers for the ALU command sequencer.
package alu_pkg;

   localparam int unsigned ALU_N = 4;
   localparam int unsigned ALU_M = 4;
   localparam int unsigned OP_W  = ALU_M - 1;
   localparam int unsigned CMD_W = OP_W + 2 * ALU_N;
   localparam int unsigned RES_W = ALU_N + OP_W + 1;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_SHL = 3'b100,
      OP_SHR = 3'b101,
      OP_ROL = 3'b110,
      OP_ROR = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [ALU_N-1:0] a;
      logic [ALU_N-1:0] b;
   } cmd_entry_t;

   typedef struct packed {
      logic [ALU_N-1:0] data;
      logic [OP_W-1:0]  op;
      logic             err;
   } res_entry_t;

   // The unit has no mul/div; for these it passes operand a through.
   function automatic logic is_unimpl(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with arbitrary depth (pointers wrap modulo Depth) and occupancy count.
module alu_sync_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4,
   localparam int unsigned CntW = $clog2(Depth) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en_i,
   input  logic [Width-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [Width-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic             do_wr, do_rd;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o    = (count_q == CntW'(Depth));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   // A write into a full FIFO is accepted only when the head leaves in the same cycle.
   assign do_rd = rd_en_i && !empty_o;
   assign do_wr = wr_en_i && (!full_o || do_rd);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr) begin
         mem_d[wr_ptr_q] = wr_data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_rd) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CntW'(do_wr) - CntW'(do_rd);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         mem_q    <= mem_d;
      end
   end

   overflow_chk : assert property (@(posedge clk) disable iff (!rst_n)
      !(wr_en_i && full_o && !rd_en_i));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one per clock under a result-buffer credit check and
// returns the unit's registered results in order with back-pressure.
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned N          = 4,
   parameter int unsigned M          = 4,
   parameter int unsigned CMD_DEPTH  = 4,
   parameter int unsigned RBUF_DEPTH = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [M-2:0] cmd_op,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   output logic [N-1:0] alu_a,
   output logic [N-1:0] alu_b,
   output logic [M-2:0] alu_instruction,
   input  logic [N-1:0] alu_result,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_data,
   output logic [M-2:0] res_op,
   output logic         res_err,
   output logic         busy
);
   localparam int unsigned OpW     = M - 1;
   localparam int unsigned CmdW    = OpW + 2 * N;
   localparam int unsigned ResW    = N + OpW + 1;
   localparam int unsigned CmdCntW = $clog2(CMD_DEPTH) + 1;
   localparam int unsigned RbCntW  = $clog2(RBUF_DEPTH) + 1;
   localparam int unsigned CrW     = RbCntW + 1;

   logic               cmd_push, cmd_full, cmd_empty, issue;
   logic [CmdW-1:0]    cmd_head;
   logic [CmdCntW-1:0] cmd_count;
   logic [OpW-1:0]     head_op;
   logic [N-1:0]       head_a, head_b;

   logic               rb_full, rb_empty, res_pop;
   logic [ResW-1:0]    rb_head;
   logic [RbCntW-1:0]  rb_count;
   logic [CrW-1:0]     credit_used;

   logic [N-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [OpW-1:0] alu_op_q, alu_op_d;
   logic           s1_v_q, s1_v_d, s1_err_q, s1_err_d;
   logic [OpW-1:0] s1_op_q, s1_op_d;
   logic           s2_v_q, s2_v_d, s2_err_q, s2_err_d;
   logic [OpW-1:0] s2_op_q, s2_op_d;

   logic unused_sig;
   assign unused_sig = ^{cmd_count, rb_full};

   assign cmd_ready = !cmd_full;
   assign cmd_push  = cmd_valid && cmd_ready;
   assign {head_op, head_a, head_b} = cmd_head;

   alu_sync_fifo #(
      .Width (CmdW),
      .Depth (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (cmd_push),
      .wr_data_i ({cmd_op, cmd_a, cmd_b}),
      .rd_en_i   (issue),
      .rd_data_o (cmd_head),
      .full_o    (cmd_full),
      .empty_o   (cmd_empty),
      .count_o   (cmd_count)
   );

   // The slot being popped this cycle is reclaimed so a draining buffer sustains full rate.
   assign res_pop     = res_valid && res_ready;
   assign credit_used = CrW'(rb_count) + CrW'(s1_v_q) + CrW'(s2_v_q) - CrW'(res_pop);
   assign issue       = !cmd_empty && (credit_used < CrW'(RBUF_DEPTH));

   always_comb begin
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      alu_op_d = alu_op_q;
      s1_v_d   = issue;
      s1_op_d  = s1_op_q;
      s1_err_d = s1_err_q;
      if (issue) begin
         alu_a_d  = head_a;
         alu_b_d  = head_b;
         alu_op_d = head_op;
         s1_op_d  = head_op;
         s1_err_d = is_unimpl(head_op);
      end
      s2_v_d   = s1_v_q;
      s2_op_d  = s1_op_q;
      s2_err_d = s1_err_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         alu_op_q <= '0;
         s1_v_q   <= 1'b0;
         s1_op_q  <= '0;
         s1_err_q <= 1'b0;
         s2_v_q   <= 1'b0;
         s2_op_q  <= '0;
         s2_err_q <= 1'b0;
      end else begin
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         alu_op_q <= alu_op_d;
         s1_v_q   <= s1_v_d;
         s1_op_q  <= s1_op_d;
         s1_err_q <= s1_err_d;
         s2_v_q   <= s2_v_d;
         s2_op_q  <= s2_op_d;
         s2_err_q <= s2_err_d;
      end
   end

   alu_sync_fifo #(
      .Width (ResW),
      .Depth (RBUF_DEPTH)
   ) u_res_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (s2_v_q),
      .wr_data_i ({alu_result, s2_op_q, s2_err_q}),
      .rd_en_i   (res_pop),
      .rd_data_o (rb_head),
      .full_o    (rb_full),
      .empty_o   (rb_empty),
      .count_o   (rb_count)
   );

   assign alu_a           = alu_a_q;
   assign alu_b           = alu_b_q;
   assign alu_instruction = alu_op_q;
   assign res_valid       = !rb_empty;
   assign {res_data, res_op, res_err} = rb_head;
   assign busy = !cmd_empty || s1_v_q || s2_v_q || !rb_empty;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed and randomised checks of alu_cmd_sequencer against a registered 4-bit ALU model.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, cmd_valid, cmd_ready, res_valid, res_ready, res_err, busy;
   logic [2:0] cmd_op, alu_instruction, res_op;
   logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_result, res_data;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;
   bit rand_rdy = 1'b0;
   logic [7:0] obs_q[$];
   logic [7:0] exp_q[$];
   int         cyc_q[$];

   always #5 clk = ~clk;

   alu_cmd_sequencer #(
      .N          (4),
      .M          (4),
      .CMD_DEPTH  (4),
      .RBUF_DEPTH (3)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_a           (cmd_a),
      .cmd_b           (cmd_b),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_instruction (alu_instruction),
      .alu_result      (alu_result),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_data        (res_data),
      .res_op          (res_op),
      .res_err         (res_err),
      .busy            (busy)
   );

   function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, b);
      case (op)
         3'b000:  return a + b;
         3'b001:  return a - b;
         3'b100:  return {a[2:0], 1'b0};
         3'b101:  return {1'b0, a[3:1]};
         3'b110:  return {a[2:0], a[3]};
         3'b111:  return {a[0], a[3:1]};
         default: return a;
      endcase
   endfunction

   function automatic logic [7:0] pk(input logic [2:0] op, input logic err, input logic [3:0] d);
      return {op, err, d};
   endfunction

   // Registered arithmetic unit: output follows the inputs one clock later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alu_result <= '0;
      else        alu_result <= alu_f(alu_instruction, alu_a, alu_b);
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n && res_valid && res_ready) begin
         obs_q.push_back(pk(res_op, res_err, res_data));
         cyc_q.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_rdy) res_ready = ($urandom_range(0, 1) == 1);
   endtask

   task automatic push(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      for (int k = 0; k < 200 && !cmd_ready; k++) step();
      chk("push_ready", cmd_ready, 1'b1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx, rv_seen;
      logic [2:0] rop;
      logic [3:0] ra, rb;
      logic acc;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
      #2;
      chk("rst_alu_a", alu_a, 4'h0);
      chk("rst_alu_instr", alu_instruction, 3'h0);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_res_data", {res_op, res_err, res_data}, 8'h00);
      chk("rst_busy", busy, 1'b0);
      idle(2);
      rst_n = 1'b1;
      step();
      chk("cmd_ready_after_rst", cmd_ready, 1'b1);

      // Single ADD 7+9 -> 0 three cycles after accept
      res_ready = 1'b1;
      push(OP_ADD, 4'd7, 4'd9);
      chk("t1_busy_after_accept", busy, 1'b1);
      chk("t1_valid_c0", res_valid, 1'b0);
      step();
      chk("t1_valid_c1", res_valid, 1'b0);
      step();
      chk("t1_valid_c2", res_valid, 1'b0);
      step();
      chk("t1_valid_c3", res_valid, 1'b1);
      chk("t1_result", {res_op, res_err, res_data}, pk(3'b000, 1'b0, 4'h0));
      chk("t1_busy_c3", busy, 1'b1);
      step();
      chk("t1_valid_after_pop", res_valid, 1'b0);
      chk("t1_busy_after_pop", busy, 1'b0);

      // Back-to-back stream, one result per clock
      idle(2);
      obs_q.delete(); cyc_q.delete();
      push(OP_SUB, 4'd3, 4'd5);
      push(OP_SHL, 4'b1001, 4'd0);
      push(OP_ROL, 4'b1001, 4'd0);
      push(OP_ROR, 4'b1001, 4'd0);
      push(OP_SHR, 4'b1001, 4'd0);
      idle(10);
      exp_q = '{pk(3'b001, 1'b0, 4'hE), pk(3'b100, 1'b0, 4'b0010), pk(3'b110, 1'b0, 4'b0011),
                pk(3'b111, 1'b0, 4'b1100), pk(3'b101, 1'b0, 4'b0100)};
      chk("t2_count", obs_q.size(), 5);
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         chk($sformatf("t2_res%0d", i), obs_q[i], exp_q[i]);
         chk($sformatf("t2_cycle%0d", i), cyc_q[i] - cyc_q[0], i);
      end
      chk("t2_idle_busy", busy, 1'b0);

      // Back-pressure: buffer plus credits cap issue, FIFO fills
      obs_q.delete();
      res_ready = 1'b0;
      idx = 0;
      cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_a = 4'd0; cmd_b = 4'd1;
      for (int k = 0; k < 20; k++) begin
         acc = cmd_valid && cmd_ready;
         step();
         if (acc) begin
            idx++;
            if (idx < 10) cmd_a = 4'(idx);
            else cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      chk("t3_accepted", idx, 7);
      chk("t3_cmd_ready", cmd_ready, 1'b0);
      chk("t3_last_issued_a", alu_a, 4'd2);
      chk("t3_res_valid", res_valid, 1'b1);
      chk("t3_none_popped", obs_q.size(), 0);
      res_ready = 1'b1;
      idle(15);
      chk("t3_drain_count", obs_q.size(), 7);
      for (int i = 0; i < 7 && i < obs_q.size(); i++)
         chk($sformatf("t3_res%0d", i), obs_q[i], pk(3'b000, 1'b0, 4'(i + 1)));
      chk("t3_cmd_ready_after", cmd_ready, 1'b1);

      // Unimplemented opcode passes a through and flags res_err
      obs_q.delete();
      push(OP_MUL, 4'd5, 4'd3);
      push(OP_ADD, 4'd1, 4'd1);
      idle(8);
      chk("t4_count", obs_q.size(), 2);
      if (obs_q.size() == 2) begin
         chk("t4_mul", obs_q[0], pk(3'b010, 1'b1, 4'd5));
         chk("t4_add", obs_q[1], pk(3'b000, 1'b0, 4'd2));
      end

      // Reset mid-operation discards everything
      obs_q.delete();
      push(OP_ADD, 4'd1, 4'd2);
      push(OP_ADD, 4'd3, 4'd4);
      push(OP_ADD, 4'd5, 4'd6);
      push(OP_ADD, 4'd7, 4'd8);
      chk("t5_busy_pre", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t5_res_valid", res_valid, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_alu_regs", {alu_a, alu_b, alu_instruction}, 11'h0);
      chk("t5_res_fields", {res_op, res_err, res_data}, 8'h00);
      chk("t5_cmd_ready", cmd_ready, 1'b1);
      idle(2);
      rst_n = 1'b1;
      rv_seen = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (res_valid) rv_seen++;
      end
      chk("t5_no_valid_after", rv_seen, 0);
      chk("t5_no_results", obs_q.size(), 0);
      push(OP_ADD, 4'd2, 4'd2);
      idle(6);
      chk("t5_new_count", obs_q.size(), 1);
      if (obs_q.size() == 1) chk("t5_new_add", obs_q[0], pk(3'b000, 1'b0, 4'd4));

      // Random commands with random back-pressure against the scoreboard
      obs_q.delete(); exp_q.delete();
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 4'($urandom_range(0, 15));
         rb  = 4'($urandom_range(0, 15));
         exp_q.push_back(pk(rop, is_unimpl(rop), alu_f(rop, ra, rb)));
         push(rop, ra, rb);
      end
      for (int k = 0; k < 3000 && obs_q.size() < 200; k++) step();
      rand_rdy = 1'b0;
      res_ready = 1'b1;
      idle(4);
      chk("t6_count", obs_q.size(), 200);
      for (int i = 0; i < 200 && i < obs_q.size(); i++)
         chk($sformatf("t6_res%0d", i), obs_q[i], exp_q[i]);
      chk("t6_idle_busy", busy, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
